// File: rtl/down_counter_seq_if.sv
// Control and counter-side signal bundle for down_counter_seq.
// The slave modport is the sequencer; master is the control logic plus counter.
interface down_counter_seq_if #(
    parameter int WIDTH = 8
);
    logic             go;
    logic             stop;
    logic             periodic;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] counter_out;
    logic             cnt_start;
    logic             cnt_reset;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [7:0]       run_cnt;

    modport slave (
        input  go,
        input  stop,
        input  periodic,
        input  term_val,
        input  counter_out,
        output cnt_start,
        output cnt_reset,
        output busy,
        output done,
        output aborted,
        output run_cnt
    );

    modport master (
        output go,
        output stop,
        output periodic,
        output term_val,
        output counter_out,
        input  cnt_start,
        input  cnt_reset,
        input  busy,
        input  done,
        input  aborted,
        input  run_cnt
    );
endinterface

// File: rtl/down_counter_seq.sv
// Sequencer for one down_counter: clear, arm, run to a terminal value,
// report done; optional periodic re-arm, abortable by stop.
module down_counter_seq #(
    parameter int WIDTH   = 8,
    parameter int CLR_CYC = 3
) (
    input  logic              clk,
    input  logic              reset,
    down_counter_seq_if.slave bus
);
    localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ARM   = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             periodic_q, periodic_d;
    logic [7:0]       run_cnt_q, run_cnt_d;
    logic             aborted_q, aborted_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            term_q     <= '0;
            periodic_q <= 1'b0;
            run_cnt_q  <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            term_q     <= term_d;
            periodic_q <= periodic_d;
            run_cnt_q  <= run_cnt_d;
            aborted_q  <= aborted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        term_d     = term_q;
        periodic_d = periodic_q;
        run_cnt_d  = run_cnt_q;
        aborted_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.go) begin
                    term_d     = bus.term_val;
                    periodic_d = bus.periodic;
                    run_cnt_d  = '0;
                    clr_cnt_d  = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ARM;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ARM: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.counter_out == term_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (run_cnt_q != 8'hFF) begin
                    run_cnt_d = run_cnt_q + 8'd1;
                end
                state_d = periodic_q ? CLEAR : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // stop wins over every transition once a run has been accepted
        if (bus.stop && (state_q != IDLE)) begin
            state_d   = IDLE;
            clr_cnt_d = '0;
            run_cnt_d = run_cnt_q;
            aborted_d = 1'b1;
        end
    end

    assign bus.cnt_reset = (state_q == CLEAR);
    assign bus.cnt_start = (state_q == RUN) && (bus.counter_out != term_q);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.aborted   = aborted_q;
    assign bus.run_cnt   = run_cnt_q;
endmodule

// File: tb/tb_down_counter_seq.sv
// Directed bench for down_counter_seq with a behavioural down_counter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_down_counter_seq;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] cnt = 8'h00;
    int checks = 0;
    int errors = 0;

    down_counter_seq_if #(.WIDTH(8)) bus ();

    down_counter_seq #(.WIDTH(8), .CLR_CYC(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.cnt_reset) cnt <= 8'hFF;
        else if (bus.cnt_start) cnt <= cnt - 8'd1;
    end
    assign bus.counter_out = cnt;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            assert (!(bus.done === 1'b1 && bus.aborted === 1'b1)) else begin
                errors++;
                $error("FAIL done_aborted_overlap: observed both 1, expected not both");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done !== 1'b1 && n < 600);
    endtask

    initial begin
        int n;
        int k;
        logic seen;

        reset = 1'b1;
        bus.go = 1'b0;
        bus.stop = 1'b0;
        bus.periodic = 1'b0;
        bus.term_val = 8'd0;

        // 1: reset
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_start", bus.cnt_start, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 0);
        chk("idle_creset", bus.cnt_reset, 0);
        chk("idle_start", bus.cnt_start, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_aborted", bus.aborted, 0);
        chk("idle_runcnt", bus.run_cnt, 0);

        // 2: one-shot, term 250
        bus.term_val = 8'd250;
        bus.periodic = 1'b0;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("clr_creset", bus.cnt_reset, 1);
            chk("clr_start", bus.cnt_start, 0);
            chk("clr_busy", bus.busy, 1);
            tick();
        end
        chk("arm_creset", bus.cnt_reset, 0);
        chk("arm_start", bus.cnt_start, 0);
        chk("arm_cnt", cnt, 255);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("run_start", bus.cnt_start, 1);
            chk("run_cnt", cnt, 255 - i);
            tick();
        end
        chk("run_end_start", bus.cnt_start, 0);
        chk("run_end_cnt", cnt, 250);
        chk("run_end_done", bus.done, 0);
        tick();
        chk("t2_done", bus.done, 1);
        chk("t2_runcnt_pre", bus.run_cnt, 0);
        tick();
        chk("t2_done_off", bus.done, 0);
        chk("t2_busy", bus.busy, 0);
        chk("t2_runcnt", bus.run_cnt, 1);
        chk("t2_cnt", cnt, 250);

        // 3: periodic, term 0
        bus.term_val = 8'd0;
        bus.periodic = 1'b1;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk("t3_runcnt_clr", bus.run_cnt, 0);
        for (int r = 1; r <= 3; r++) begin
            wait_done(n);
            chk("t3_period", n, 260);
            chk("t3_cnt0", cnt, 0);
            tick();
            chk("t3_runcnt", bus.run_cnt, r);
            chk("t3_rearm", bus.cnt_reset, 1);
        end

        // 4: stop mid-run at 100
        k = 0;
        while (!(bus.cnt_start === 1'b1 && cnt == 8'd100) && k < 400) begin
            tick();
            k++;
        end
        chk("t4_reach100", (k < 400), 1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t4_busy", bus.busy, 0);
        chk("t4_start", bus.cnt_start, 0);
        chk("t4_aborted", bus.aborted, 1);
        chk("t4_done", bus.done, 0);
        chk("t4_cnt", (cnt == 8'd99 || cnt == 8'd100), 1);
        chk("t4_runcnt", bus.run_cnt, 3);
        tick();
        chk("t4_aborted_off", bus.aborted, 0);
        chk("t4_hold", (cnt == 8'd99 || cnt == 8'd100), 1);
        chk("t4_idle", bus.busy, 0);

        // 5: term 255, with stop+go together in IDLE
        bus.term_val = 8'd255;
        bus.periodic = 1'b0;
        bus.go = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.go = 1'b0;
        bus.stop = 1'b0;
        chk("t5_accept", bus.busy, 1);
        chk("t5_runcnt_clr", bus.run_cnt, 0);
        seen = bus.cnt_start;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
            seen = seen | bus.cnt_start;
        end
        chk("t5_latency", n, 5);
        chk("t5_no_start", seen, 0);
        chk("t5_no_abort", bus.aborted, 0);
        tick();
        chk("t5_runcnt", bus.run_cnt, 1);
        chk("t5_idle", bus.busy, 0);

        // 6: changes during run are ignored
        bus.term_val = 8'd250;
        bus.periodic = 1'b0;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        repeat (4) tick();
        chk("t6_in_run", bus.cnt_start, 1);
        bus.term_val = 8'd10;
        bus.periodic = 1'b1;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        wait_done(n);
        chk("t6_latency", n, 5);
        chk("t6_cnt", cnt, 250);
        tick();
        chk("t6_idle", bus.busy, 0);
        chk("t6_runcnt", bus.run_cnt, 1);
        tick();
        chk("t6_stay_idle", bus.busy, 0);

        // reset in the middle of a run
        bus.term_val = 8'd0;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        repeat (6) tick();
        chk("rr_running", bus.cnt_start, 1);
        reset = 1'b1;
        tick();
        chk("rr_busy", bus.busy, 0);
        chk("rr_start", bus.cnt_start, 0);
        chk("rr_runcnt", bus.run_cnt, 0);
        reset = 1'b0;
        tick();
        chk("rr_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
